// File: rtl/reg_file_scoreboard_if.sv
// Port bundle for reg_file_scoreboard: ID read ports, issue port, WB write port and scoreboard status.
// WORD_LEN defaults to `WORD_LEN (32 when no defines file supplies it).
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

interface reg_file_scoreboard_if #(
   parameter int WORD_LEN = `WORD_LEN,
   parameter int ADDR_LEN = 5,
   parameter int NUM_REGS = 32
);
   // No valid/ready pair: issue_en and WB_EN are single-cycle qualifiers sampled on every rising
   // clk edge and always accepted; the ID stage itself must hold issue_en low while hazard is high.
   logic [ADDR_LEN-1:0] src1;
   logic [ADDR_LEN-1:0] src2;
   logic [WORD_LEN-1:0] reg1;
   logic [WORD_LEN-1:0] reg2;
   logic                issue_en;
   logic [ADDR_LEN-1:0] issue_dest;
   logic                WB_EN;
   logic [ADDR_LEN-1:0] WB_dest;
   logic [WORD_LEN-1:0] WB_res;
   logic                hazard;
   logic [NUM_REGS-1:0] pending;
   logic                sb_overflow;

   modport master (
      output src1, src2, issue_en, issue_dest, WB_EN, WB_dest, WB_res,
      input  reg1, reg2, hazard, pending, sb_overflow
   );

   modport slave (
      input  src1, src2, issue_en, issue_dest, WB_EN, WB_dest, WB_res,
      output reg1, reg2, hazard, pending, sb_overflow
   );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Register file with a per-register 2-bit outstanding-write scoreboard driving the ID-stage stall.
// Optional macro WB_BYPASS_EN forwards same-cycle write-back data to the read ports.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module reg_file_scoreboard #(
   parameter int WORD_LEN = `WORD_LEN,
   parameter int ADDR_LEN = 5,
   parameter int NUM_REGS = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   reg_file_scoreboard_if.slave bus
);
   logic [WORD_LEN-1:0] regs_q [NUM_REGS];
   logic [WORD_LEN-1:0] regs_d [NUM_REGS];
   logic [1:0]          cnt_q  [NUM_REGS];
   logic [1:0]          cnt_d  [NUM_REGS];
   logic                ovf_q;
   logic                ovf_d;

   logic [NUM_REGS-1:0] inc;
   logic [NUM_REGS-1:0] dec;

   logic [ADDR_LEN-1:0] src   [2];
   logic [WORD_LEN-1:0] rdata [2];
   logic [1:0]          busy;

   // Entry 0 is never decoded, so it can never be written or counted.
   always_comb begin
      inc = '0;
      dec = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         inc[i] = bus.issue_en && (int'(bus.issue_dest) == i);
         dec[i] = bus.WB_EN && (int'(bus.WB_dest) == i);
      end
   end

   always_comb begin
      regs_d = regs_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (dec[i]) regs_d[i] = bus.WB_res;
         if (inc[i] && !dec[i]) begin
            if (cnt_q[i] == 2'd3) ovf_d = 1'b1;
            else                  cnt_d[i] = cnt_q[i] + 2'd1;
         end else if (dec[i] && !inc[i] && cnt_q[i] != 2'd0) begin
            cnt_d[i] = cnt_q[i] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         ovf_q <= 1'b0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
      end
   end

   assign src[0] = bus.src1;
   assign src[1] = bus.src2;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = '0;
         busy[p]  = 1'b0;
         if (src[p] != '0 && int'(src[p]) < NUM_REGS) begin
            rdata[p] = regs_q[src[p]];
            busy[p]  = (cnt_q[src[p]] != 2'd0);
`ifdef WB_BYPASS_EN
            // The last outstanding write lands this cycle, so forwarding resolves the dependency.
            if (rst && bus.WB_EN && bus.WB_dest == src[p]) begin
               rdata[p] = bus.WB_res;
               if (cnt_q[src[p]] == 2'd1) busy[p] = 1'b0;
            end
`endif
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) bus.pending[i] = (cnt_q[i] != 2'd0);
   end

   assign bus.reg1        = rdata[0];
   assign bus.reg2        = rdata[1];
   assign bus.hazard      = |busy;
   assign bus.sb_overflow = ovf_q;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard: directed scenarios plus random traffic vs a reference model.
module tb_reg_file_scoreboard;
   localparam int W = 32;
   localparam int A = 5;
   localparam int N = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_file_scoreboard_if #(.WORD_LEN(W), .ADDR_LEN(A), .NUM_REGS(N)) bus ();
   reg_file_scoreboard #(.WORD_LEN(W), .ADDR_LEN(A), .NUM_REGS(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: register contents, outstanding-write counts as plain integers, sticky overflow.
   logic [W-1:0] m_regs [N];
   int           m_cnt  [N];
   bit           m_ovf;
   logic [W-1:0] exp_q [$];

   function automatic void m_reset();
      for (int i = 0; i < N; i++) begin
         m_regs[i] = '0;
         m_cnt[i]  = 0;
      end
      m_ovf = 1'b0;
   endfunction

   function automatic logic [W-1:0] m_read(input logic [A-1:0] a);
      if (!rst || a == 0) return '0;
`ifdef WB_BYPASS_EN
      if (bus.WB_EN && bus.WB_dest == a) return bus.WB_res;
`endif
      return m_regs[a];
   endfunction

   function automatic bit m_busy(input logic [A-1:0] a);
      if (!rst || a == 0) return 1'b0;
`ifdef WB_BYPASS_EN
      if (m_cnt[a] == 1 && bus.WB_EN && bus.WB_dest == a) return 1'b0;
`endif
      return m_cnt[a] > 0;
   endfunction

   function automatic logic [N-1:0] m_pending();
      logic [N-1:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = (m_cnt[i] > 0);
      return v;
   endfunction

   // Apply the effect of one rising edge given the inputs currently driven.
   function automatic void m_edge();
      int id;
      int wd;
      if (!rst) begin
         m_reset();
         return;
      end
      id = bus.issue_en ? int'(bus.issue_dest) : 0;
      wd = bus.WB_EN ? int'(bus.WB_dest) : 0;
      if (wd != 0) m_regs[wd] = bus.WB_res;
      if (id != 0 && id == wd) return;
      if (id != 0) begin
         if (m_cnt[id] == 3) m_ovf = 1'b1;
         else                m_cnt[id] = m_cnt[id] + 1;
      end
      if (wd != 0) m_cnt[wd] = (m_cnt[wd] > 0) ? m_cnt[wd] - 1 : 0;
   endfunction

   task automatic set_in(input bit iss, input int idest, input bit wb, input int wdest,
                         input logic [W-1:0] wres, input int s1, input int s2);
      bus.issue_en   = iss;
      bus.issue_dest = A'(idest);
      bus.WB_EN      = wb;
      bus.WB_dest    = A'(wdest);
      bus.WB_res     = wres;
      bus.src1       = A'(s1);
      bus.src2       = A'(s2);
   endtask

   task automatic tick();
      @(posedge clk);
      m_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, $urandom_range(0, 31), 1'b1, $urandom_range(0, 31), $urandom,
                $urandom_range(0, 31), $urandom_range(0, 31));
         #1;
         tests_run += 5;
         if (bus.reg1 !== '0) begin tests_failed++; $display("FAIL reset_reg1 got %h exp 0", bus.reg1); end
         if (bus.reg2 !== '0) begin tests_failed++; $display("FAIL reset_reg2 got %h exp 0", bus.reg2); end
         if (bus.hazard !== 1'b0) begin tests_failed++; $display("FAIL reset_hazard got %b exp 0", bus.hazard); end
         if (bus.pending !== '0) begin tests_failed++; $display("FAIL reset_pending got %h exp 0", bus.pending); end
         if (bus.sb_overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b exp 0", bus.sb_overflow); end
         tick();
      end
      rst = 1'b1;
      set_in(0, 0, 0, 0, '0, 0, 0);
      m_reset();
   endtask

   task automatic test_write_read();
      set_in(0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
      tick();
      set_in(0, 0, 1, 0, 32'h0000_1234, 0, 0);
      tick();
      set_in(0, 0, 0, 0, '0, 5, 0);
      #1;
      tests_run += 4;
      if (bus.reg1 !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL wr_reg1 got %h exp deadbeef", bus.reg1); end
      if (bus.reg2 !== '0) begin tests_failed++; $display("FAIL wr_reg0 got %h exp 0", bus.reg2); end
      if (bus.pending !== '0) begin tests_failed++; $display("FAIL wr_no_underflow got %h exp 0", bus.pending); end
      if (bus.hazard !== 1'b0) begin tests_failed++; $display("FAIL wr_hazard got %b exp 0", bus.hazard); end
      @(negedge clk);
   endtask

   task automatic test_scoreboard();
      for (int k = 0; k < 3; k++) begin
         set_in(1, 7, 0, 0, '0, 0, 0);
         tick();
      end
      set_in(0, 0, 0, 0, '0, 7, 0);
      #1;
      tests_run += 3;
      if (bus.pending[7] !== 1'b1) begin tests_failed++; $display("FAIL sb_pending7 got %b exp 1", bus.pending[7]); end
      if (bus.hazard !== 1'b1) begin tests_failed++; $display("FAIL sb_hazard got %b exp 1", bus.hazard); end
      if (bus.sb_overflow !== 1'b0) begin tests_failed++; $display("FAIL sb_ovf_early got %b exp 0", bus.sb_overflow); end
      @(negedge clk);
      set_in(1, 7, 0, 0, '0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, '0, 7, 0);
      #1;
      tests_run += 2;
      if (bus.sb_overflow !== 1'b1) begin tests_failed++; $display("FAIL sb_ovf got %b exp 1", bus.sb_overflow); end
      if (bus.pending !== m_pending()) begin tests_failed++; $display("FAIL sb_pending_sat got %h exp %h", bus.pending, m_pending()); end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         set_in(0, 0, 1, 7, $urandom, 0, 0);
         tick();
         set_in(0, 0, 0, 0, '0, 7, 0);
         #1;
         tests_run += 2;
         if (bus.pending[7] !== (k < 2)) begin tests_failed++; $display("FAIL sb_drain%0d got %b exp %b", k, bus.pending[7], k < 2); end
         if (bus.hazard !== (k < 2)) begin tests_failed++; $display("FAIL sb_hazard_drain%0d got %b exp %b", k, bus.hazard, k < 2); end
         @(negedge clk);
      end
      tests_run++;
      if (bus.sb_overflow !== 1'b1) begin tests_failed++; $display("FAIL sb_ovf_sticky got %b exp 1", bus.sb_overflow); end
   endtask

   task automatic test_simultaneous();
      set_in(1, 3, 0, 0, '0, 0, 0);
      tick();
      set_in(1, 3, 1, 3, 32'h3333, 0, 0);
      tick();
      #1;
      tests_run++;
      if (bus.pending[3] !== 1'b1) begin tests_failed++; $display("FAIL sim_same_pending3 got %b exp 1", bus.pending[3]); end
      @(negedge clk);
      set_in(1, 4, 1, 3, 32'h4444, 0, 0);
      tick();
      set_in(0, 0, 0, 0, '0, 3, 4);
      #1;
      tests_run += 3;
      if (bus.pending[3] !== 1'b0) begin tests_failed++; $display("FAIL sim_pending3 got %b exp 0", bus.pending[3]); end
      if (bus.pending[4] !== 1'b1) begin tests_failed++; $display("FAIL sim_pending4 got %b exp 1", bus.pending[4]); end
      if (bus.reg1 !== 32'h4444) begin tests_failed++; $display("FAIL sim_reg3 got %h exp 4444", bus.reg1); end
      @(negedge clk);
      set_in(0, 0, 1, 4, 32'h4, 0, 0);
      tick();
   endtask

   task automatic test_bypass();
      set_in(0, 0, 1, 9, 32'hAA, 0, 0);
      tick();
      set_in(1, 9, 0, 0, '0, 0, 0);
      tick();
      set_in(0, 0, 1, 9, 32'h55, 9, 0);
      #1;
      tests_run += 2;
`ifdef WB_BYPASS_EN
      if (bus.reg1 !== 32'h55) begin tests_failed++; $display("FAIL byp_reg1 got %h exp 55", bus.reg1); end
      if (bus.hazard !== 1'b0) begin tests_failed++; $display("FAIL byp_hazard got %b exp 0", bus.hazard); end
`else
      if (bus.reg1 !== 32'hAA) begin tests_failed++; $display("FAIL byp_reg1 got %h exp aa", bus.reg1); end
      if (bus.hazard !== 1'b1) begin tests_failed++; $display("FAIL byp_hazard got %b exp 1", bus.hazard); end
`endif
      tick();
      set_in(0, 0, 0, 0, '0, 9, 0);
      #1;
      tests_run += 2;
      if (bus.reg1 !== 32'h55) begin tests_failed++; $display("FAIL byp_next_reg1 got %h exp 55", bus.reg1); end
      if (bus.hazard !== 1'b0) begin tests_failed++; $display("FAIL byp_next_hazard got %b exp 0", bus.hazard); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      set_in(1, 10, 0, 0, '0, 0, 0);
      tick();
      set_in(1, 11, 1, 12, 32'hC0FFEE, 0, 0);
      tick();
      set_in(1, 11, 0, 0, '0, 11, 12);
      tick();
      set_in(0, 0, 0, 0, '0, 11, 12);
      #1;
      tests_run++;
      if (bus.pending !== m_pending()) begin tests_failed++; $display("FAIL mid_pre_pending got %h exp %h", bus.pending, m_pending()); end
      rst = 1'b0;
      #1;
      tests_run += 4;
      if (bus.pending !== '0) begin tests_failed++; $display("FAIL mid_pending got %h exp 0", bus.pending); end
      if (bus.hazard !== 1'b0) begin tests_failed++; $display("FAIL mid_hazard got %b exp 0", bus.hazard); end
      if (bus.reg2 !== '0) begin tests_failed++; $display("FAIL mid_reg2 got %h exp 0", bus.reg2); end
      if (bus.sb_overflow !== 1'b0) begin tests_failed++; $display("FAIL mid_ovf got %b exp 0", bus.sb_overflow); end
      #1;
      rst = 1'b1;
      m_reset();
      @(negedge clk);
      set_in(0, 0, 1, 11, 32'h11, 0, 0);
      tick();
      set_in(1, 11, 0, 0, '0, 11, 0);
      tick();
      set_in(0, 0, 0, 0, '0, 11, 0);
      #1;
      tests_run += 2;
      if (bus.pending !== (N'(1) << 11)) begin tests_failed++; $display("FAIL mid_after_pending got %h exp %h", bus.pending, N'(1) << 11); end
      if (bus.reg1 !== 32'h11) begin tests_failed++; $display("FAIL mid_after_reg1 got %h exp 11", bus.reg1); end
      @(negedge clk);
      set_in(0, 0, 1, 11, 32'h22, 0, 0);
      tick();
   endtask

   task automatic test_random();
      logic [W-1:0] e;
      for (int k = 0; k < 400; k++) begin
         set_in($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom, $urandom_range(0, 7), $urandom_range(0, 7));
         #1;
         exp_q.push_back(m_read(bus.src1));
         exp_q.push_back(m_read(bus.src2));
         tests_run += 5;
         e = exp_q.pop_front();
         if (bus.reg1 !== e) begin tests_failed++; $display("FAIL rnd_reg1 cyc%0d got %h exp %h", k, bus.reg1, e); end
         e = exp_q.pop_front();
         if (bus.reg2 !== e) begin tests_failed++; $display("FAIL rnd_reg2 cyc%0d got %h exp %h", k, bus.reg2, e); end
         if (bus.hazard !== (m_busy(bus.src1) | m_busy(bus.src2))) begin
            tests_failed++; $display("FAIL rnd_hazard cyc%0d got %b exp %b", k, bus.hazard, m_busy(bus.src1) | m_busy(bus.src2));
         end
         if (bus.pending !== m_pending()) begin tests_failed++; $display("FAIL rnd_pending cyc%0d got %h exp %h", k, bus.pending, m_pending()); end
         if (bus.sb_overflow !== m_ovf) begin tests_failed++; $display("FAIL rnd_ovf cyc%0d got %b exp %b", k, bus.sb_overflow, m_ovf); end
         tick();
      end
   endtask

   initial begin
      rst = 1'b0;
      set_in(0, 0, 0, 0, '0, 0, 0);
      m_reset();
      @(negedge clk);
      test_reset();
      test_write_read();
      test_scoreboard();
      test_simultaneous();
      test_bypass();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
